// File: rtl/spdch_p2s_pkg.sv
// -----------------------------------------------------------------------------
// spdch_p2s_pkg
// Shared definitions for the spdch parallel-to-serial output stage.
//   state_e : controller state, IDLE waits for a word, SHIFT presents bits.
// -----------------------------------------------------------------------------
package spdch_p2s_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage : spdch_p2s_pkg

// File: rtl/spdch_p2s_bitcnt.sv
// -----------------------------------------------------------------------------
// spdch_p2s_bitcnt
// Counts bits of the current word that have been accepted downstream.
//   ck   : clock, rising edge
//   rn   : asynchronous active-low reset
//   clr  : restart at 0 (takes priority over inc)
//   inc  : advance by one
//   last : counter sits on the final bit position (width-1)
// -----------------------------------------------------------------------------
module spdch_p2s_bitcnt #(
   parameter int cnt_w = 3,
   parameter int width = 8
) (
   input  logic ck,
   input  logic rn,
   input  logic clr,
   input  logic inc,
   output logic last
);

   localparam logic [cnt_w-1:0] LAST_CNT = cnt_w'(width - 1);

   logic [cnt_w-1:0] cnt_q;
   logic [cnt_w-1:0] cnt_d;

   always_comb begin
      // NOTE: defaulting every always_comb output first means no path leaves it
      // unassigned, so no latch is inferred.
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + cnt_w'(1);
      end
   end

   // NOTE: all state flops use non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge ck or negedge rn) begin
      if (!rn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The counter is cleared on the final transfer, so it never passes width-1.
   assign last = (cnt_q == LAST_CNT);

endmodule : spdch_p2s_bitcnt

// File: rtl/spdch_p2s.sv
// -----------------------------------------------------------------------------
// spdch_p2s
// Parallel-to-serial output stage: takes a width-bit word over a valid/ready
// load handshake and emits it one bit per transfer, flagging the final bit.
// Back-to-back words stream with no bubble: the last bit's transfer may load
// the next word in the same cycle.
//   ck       : clock, rising edge
//   rn       : asynchronous active-low reset
//   d        : parallel word to serialize
//   ld_vld   : d is valid
//   ld_rdy   : a word can be accepted this cycle (depends on so_rdy)
//   so       : serial data bit (0 when idle)
//   so_vld   : so is valid
//   so_last  : so is the final bit of the current word
//   so_rdy   : downstream accepts so this cycle
// -----------------------------------------------------------------------------
module spdch_p2s
   import spdch_p2s_pkg::*;
#(
   parameter int width     = 8,
   parameter int cnt_w     = 3,
   parameter bit msb_first = 1'b1
) (
   input  logic             ck,
   input  logic             rn,
   input  logic [width-1:0] d,
   input  logic             ld_vld,
   output logic             ld_rdy,
   output logic             so,
   output logic             so_vld,
   output logic             so_last,
   input  logic             so_rdy
);

   state_e           state_q;
   state_e           state_d;
   logic [width-1:0] shreg_q;
   logic [width-1:0] shreg_d;
   logic             last;
   logic             load;
   logic             xfer;

   // Output decode straight from the registers so nothing waits on a flop.
   assign so_vld  = (state_q == ST_SHIFT);
   assign so      = so_vld & (msb_first ? shreg_q[width-1] : shreg_q[0]);
   assign so_last = so_vld & last;
   assign xfer    = so_vld & so_rdy;
   // Ready also while the final bit is leaving: this is the no-bubble path.
   assign ld_rdy  = (state_q == ST_IDLE) | (xfer & so_last);
   assign load    = ld_vld & ld_rdy;

   spdch_p2s_bitcnt #(
      .cnt_w (cnt_w),
      .width (width)
   ) u_bitcnt (
      .ck   (ck),
      .rn   (rn),
      .clr  (load | (xfer & so_last)),
      .inc  (xfer & ~so_last),
      .last (last)
   );

   // load can only be true in IDLE or on the final transfer, so it wins.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      if (load) begin
         shreg_d = d;
         state_d = ST_SHIFT;
      end else if (xfer & so_last) begin
         shreg_d = '0;
         state_d = ST_IDLE;
      end else if (xfer) begin
         shreg_d = msb_first ? (shreg_q << 1) : (shreg_q >> 1);
      end
   end

   // NOTE: the shift register is reset too, so so can never carry X after a
   // mid-word reset or at power-up.
   always_ff @(posedge ck or negedge rn) begin
      if (!rn) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

endmodule : spdch_p2s

// File: tb/tb_spdch_p2s.sv
// -----------------------------------------------------------------------------
// tb_spdch_p2s
// Three instances share ld_vld/so_rdy: 8-bit MSB-first, 8-bit LSB-first and
// 1-bit. Each has a reference model holding the bits still to be sent as a
// queue of {bit, last} entries built from the loaded word.
// -----------------------------------------------------------------------------
module tb_spdch_p2s;

   localparam int N = 3;
   localparam int WID  [N] = '{8, 8, 1};
   localparam bit MSBF [N] = '{1'b1, 1'b0, 1'b1};

   logic         ck     = 1'b0;
   logic         rn     = 1'b0;
   logic [7:0]   d      = '0;
   logic         ld_vld = 1'b0;
   logic         so_rdy = 1'b0;
   logic [N-1:0] ld_rdy;
   logic [N-1:0] so;
   logic [N-1:0] so_vld;
   logic [N-1:0] so_last;

   int n_chk  = 0;
   int n_pass = 0;

   logic [1:0] exp_q [N][$];
   logic [7:0] cap;

   spdch_p2s #(.width(8), .cnt_w(3), .msb_first(1'b1)) u_msb (
      .ck(ck), .rn(rn), .d(d), .ld_vld(ld_vld), .ld_rdy(ld_rdy[0]),
      .so(so[0]), .so_vld(so_vld[0]), .so_last(so_last[0]), .so_rdy(so_rdy));

   spdch_p2s #(.width(8), .cnt_w(3), .msb_first(1'b0)) u_lsb (
      .ck(ck), .rn(rn), .d(d), .ld_vld(ld_vld), .ld_rdy(ld_rdy[1]),
      .so(so[1]), .so_vld(so_vld[1]), .so_last(so_last[1]), .so_rdy(so_rdy));

   spdch_p2s #(.width(1), .cnt_w(1), .msb_first(1'b1)) u_w1 (
      .ck(ck), .rn(rn), .d(d[0:0]), .ld_vld(ld_vld), .ld_rdy(ld_rdy[2]),
      .so(so[2]), .so_vld(so_vld[2]), .so_last(so_last[2]), .so_rdy(so_rdy));

   always #5 ck = ~ck;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // One clock cycle: drive inputs, check at the falling edge, then advance
   // the models past the rising edge.
   task automatic step(input logic v, input logic [7:0] dv, input logic r);
      bit ld [N];
      bit xf [N];
      logic e_vld, e_so, e_last, e_rdy;
      ld_vld = v;
      d      = dv;
      so_rdy = r;
      @(negedge ck);
      for (int i = 0; i < N; i++) begin
         e_vld  = (exp_q[i].size() > 0);
         e_so   = e_vld ? exp_q[i][0][1] : 1'b0;
         e_last = e_vld ? exp_q[i][0][0] : 1'b0;
         e_rdy  = !e_vld || (r && e_last);
         check($sformatf("so_vld[%0d]", i),  32'(so_vld[i]),  32'(e_vld));
         check($sformatf("so[%0d]", i),      32'(so[i]),      32'(e_so));
         check($sformatf("so_last[%0d]", i), 32'(so_last[i]), 32'(e_last));
         check($sformatf("ld_rdy[%0d]", i),  32'(ld_rdy[i]),  32'(e_rdy));
         ld[i] = v && e_rdy;
         xf[i] = e_vld && r;
      end
      if (so_vld[0] && r) cap = {cap[6:0], so[0]};
      @(posedge ck);
      #1;
      for (int i = 0; i < N; i++) begin
         if (xf[i]) void'(exp_q[i].pop_front());
         if (ld[i]) begin
            for (int b = 0; b < WID[i]; b++) begin
               int idx;
               idx = MSBF[i] ? (WID[i] - 1 - b) : b;
               exp_q[i].push_back({dv[idx], (b == WID[i] - 1)});
            end
         end
      end
   endtask

   // Asynchronous reset between edges: outputs must drop without a clock.
   task automatic mid_reset();
      rn = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         check($sformatf("rst_so_vld[%0d]", i), 32'(so_vld[i]), 32'd0);
         check($sformatf("rst_so[%0d]", i),     32'(so[i]),     32'd0);
         check($sformatf("rst_ld_rdy[%0d]", i), 32'(ld_rdy[i]), 32'd1);
         exp_q[i].delete();
      end
      #1;
      rn = 1'b1;
   endtask

   initial begin
      // Reset held with ld_vld asserted and the clock running.
      rn = 1'b0; ld_vld = 1'b1; d = 8'hA5; so_rdy = 1'b1;
      repeat (3) begin
         @(negedge ck);
         for (int i = 0; i < N; i++) begin
            check($sformatf("reset_so_vld[%0d]", i),  32'(so_vld[i]),  32'd0);
            check($sformatf("reset_so[%0d]", i),      32'(so[i]),      32'd0);
            check($sformatf("reset_so_last[%0d]", i), 32'(so_last[i]), 32'd0);
            check($sformatf("reset_ld_rdy[%0d]", i),  32'(ld_rdy[i]),  32'd1);
         end
      end
      rn = 1'b1; ld_vld = 1'b0;
      @(posedge ck);
      #1;

      // Single word.
      cap = '0;
      step(1'b1, 8'hA5, 1'b1);
      repeat (9) step(1'b0, 8'h00, 1'b1);
      check("single_word_seq", 32'(cap), 32'hA5);

      // Back-to-back words, no gap.
      step(1'b1, 8'hA5, 1'b1);
      repeat (8) step(1'b1, 8'h3C, 1'b1);
      cap = '0;
      repeat (9) step(1'b0, 8'h00, 1'b1);
      check("b2b_second_word", 32'(cap), 32'h3C);

      // Backpressure on bits 3..5.
      cap = '0;
      step(1'b1, 8'hA5, 1'b1);
      repeat (2) step(1'b0, 8'h00, 1'b1);
      repeat (3) step(1'b1, 8'h00, 1'b0);
      repeat (8) step(1'b0, 8'h00, 1'b1);
      check("backpressure_seq", 32'(cap), 32'hA5);

      // Reset in the middle of a word, then a fresh word.
      step(1'b1, 8'hA5, 1'b1);
      repeat (4) step(1'b0, 8'h00, 1'b1);
      mid_reset();
      cap = '0;
      step(1'b1, 8'hFF, 1'b1);
      repeat (9) step(1'b0, 8'h00, 1'b1);
      check("after_reset_seq", 32'(cap), 32'hFF);

      // LSB-first walking one; the model covers the u_lsb bit order.
      step(1'b1, 8'h01, 1'b1);
      repeat (9) step(1'b0, 8'h00, 1'b1);

      // Randomized traffic with one asynchronous reset along the way.
      for (int c = 0; c < 600; c++) begin
         if (c == 300) mid_reset();
         step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_spdch_p2s

// File: doc/spdch_p2s.md
Name: spdch_p2s

Overview:
- Parallel-to-serial output stage. Sits directly downstream of the spdch register and mux cells that assemble a parallel word.
- Accepts a width-bit word over a valid/ready load handshake and emits it one bit per transfer over a valid/ready serial handshake.
- Flags the final bit of each word.
- Back-to-back words stream with no bubble cycle.

Parameters:
- width, 8, word length in bits; legal range 1..2**cnt_w.
- cnt_w, 3, bit-counter width; must satisfy 2**cnt_w >= width.
- msb_first, 1, 1 = shift out d[width-1] first, 0 = shift out d[0] first.

Ports:
- ck  input  1  clock, rising edge.
- rn  input  1  reset, asynchronous, active-low.
- d  input  width  parallel word to serialize.
- ld_vld  input  1  d is valid.
- ld_rdy  output  1  block can accept a word this cycle.
- so  output  1  serial data bit.
- so_vld  output  1  so is valid.
- so_last  output  1  so is the final bit of the current word.
- so_rdy  input  1  downstream accepts so this cycle.

Behaviour:
- Single clock ck; reset rn is asynchronous, active-low.
- Registers: state (IDLE/SHIFT), shreg[width-1:0], cnt[cnt_w-1:0].
- Reset (rn=0), applied immediately and independent of ck:
  - state=IDLE, shreg=0, cnt=0.
  - Outputs: so_vld=0, so=0, so_last=0, ld_rdy=1.
- Output decode (combinational from registers and so_rdy):
  - so_vld = (state==SHIFT).
  - so = shreg[width-1] if msb_first, else shreg[0]; forced 0 when so_vld=0.
  - so_last = so_vld & (cnt==width-1).
  - ld_rdy = (state==IDLE) | (so_vld & so_rdy & so_last).
- Events:
  - load = ld_vld & ld_rdy.
  - xfer = so_vld & so_rdy.
- IDLE:
  - load -> shreg<=d, cnt<=0, state<=SHIFT.
  - no load -> hold.
- SHIFT:
  - xfer & ~so_last -> shreg shifts toward the output end (left if msb_first, else right), fill bit 0, cnt<=cnt+1.
  - xfer & so_last & load -> shreg<=d, cnt<=0, stay in SHIFT. This is the no-bubble path.
  - xfer & so_last & ~load -> state<=IDLE, cnt<=0, shreg<=0.
  - ~xfer -> shreg, cnt and state all hold; so and so_last stable.
- Latency: a word loaded at edge N presents its first bit after edge N. With so_rdy held high, one word takes width cycles.
- ld_vld and d are sampled only when load=1. d may change freely at other times.
- ld_rdy depends combinationally on so_rdy. Upstream must not make ld_vld depend on ld_rdy.
- width=1: so_last=1 whenever so_vld=1; every xfer either reloads or returns to IDLE.
- cnt never exceeds width-1, so it does not wrap.
- Reset mid-word: the word is discarded and so_vld drops asynchronously. After rn rises, the next load starts a fresh word.
- No X propagation: all registers are reset; so is gated to 0 in IDLE.

Decomposition:
- Shared include spdch_defs.vh:
  - state encodings `SPDCH_P2S_IDLE=1'b0, `SPDCH_P2S_SHIFT=1'b1.
- Sub-module spdch_bitcnt:
  - parameters cnt_w and width.
  - inputs ck, rn, clr, inc.
  - outputs cnt and last (cnt==width-1).
  - instantiated once.
- State and shreg registers may use spdch_fd2_v instances with async active-low rn.
- The next-state mux may use spdch_mx21_v.

Test Plan (width=8, cnt_w=3, msb_first=1 unless noted):
1. Reset: rn=0 while ld_vld=1 and ck toggles -> so_vld=0, so=0, so_last=0, ld_rdy=1. No load occurs until rn=1.
2. Single word: load d=8'hA5 with so_rdy=1 -> so sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles; so_last=1 only on the 8th; ld_rdy=1 on the 8th; IDLE on the 9th.
3. Back-to-back: ld_vld held with 8'hA5 then 8'h3C, so_rdy=1 -> 16 contiguous valid bits 10100101_00111100, so_last on bits 8 and 16, no gap cycle.
4. Backpressure: d=8'hA5, so_rdy=0 during bits 3-5 -> so holds 1 (bit index 5) for 3 cycles, ld_rdy=0, total 11 cycles, sequence unchanged.
5. Reset mid-word: after 4 bits of 8'hA5, pulse rn=0 between edges -> so_vld falls before the next edge; then load 8'hFF -> eight 1s starting fresh.
6. msb_first=0, load 8'h01 -> so = 1,0,0,0,0,0,0,0, so_last on the 8th. Repeat with width=1, cnt_w=1, d=1'b1 -> one-cycle word with so_last=1.
